// File: rtl/apb_master_bridge_p.sv
// APB master bridge: one APB transfer per valid/ready command, one-hot PSEL decode
// over NSLV slaves, registered response pulse, optional wait-state timeout.
module apb_master_bridge_p #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [NSLV-1:0]   PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int SEL_W = $clog2(NSLV);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_tmo_q, rsp_tmo_d;

  logic timeout_hit, done, can_accept;

  function automatic logic [NSLV-1:0] slv_dec(input logic [ADDR_W-1:0] a);
    logic [NSLV-1:0] s;
    s = '0;
    s[a[ADDR_W-1 -: SEL_W]] = 1'b1;
    return s;
  endfunction

  // wait_q counts PREADY=0 cycles already seen, so this is the TIMEOUT-th one
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !PREADY &&
                       (wait_q == CNT_W'(TIMEOUT - 1));
  assign done        = (state_q == ACCESS) && (PREADY || timeout_hit);
  assign can_accept  = (state_q == IDLE) || done;
  // gated by reset so every output reads 0 while reset is held
  assign req_ready   = !PRESET && can_accept;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    case (state_q)
      IDLE: ;
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        if (!PREADY && wait_q != {CNT_W{1'b1}}) wait_d = wait_q + 1'b1;
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (!pwrite_q && !timeout_hit) ? PRDATA : '0;
          rsp_err_d   = timeout_hit | (PREADY & PSLVERR);
          rsp_tmo_d   = timeout_hit;
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new command overrides the return to IDLE, giving back-to-back transfers
    if (can_accept && req_valid) begin
      state_d   = SETUP;
      psel_d    = slv_dec(req_addr);
      penable_d = 1'b0;
      paddr_d   = req_addr;
      pwrite_d  = req_write;
      if (req_write) pwdata_d = req_wdata;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_tmo_q;

endmodule

// File: tb/tb_apb_master_bridge_p.sv
// Bench for apb_master_bridge_p: directed scenarios plus random commands checked
// against a per-command timeline model (SETUP, N ACCESS cycles, response pulse).
module tb_apb_master_bridge_p;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int NSLV    = 4;
  localparam int TIMEOUT = 16;

  logic              PCLK, PRESET;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic [NSLV-1:0]   PSEL;
  logic              PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              PREADY, PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] last_wdata;

  apb_master_bridge_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One full command from IDLE: nwait PREADY=0 cycles before PREADY=1.
  task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int nwait, input logic slverr, input logic [DATA_W-1:0] rdata,
                         input string name);
    logic [NSLV-1:0]   esel;
    logic              tmo, eerr;
    logic [DATA_W-1:0] erd;
    int                nacc;
    esel = '0;
    esel[addr[ADDR_W-1 -: 2]] = 1'b1;
    tmo  = (TIMEOUT > 0) && (nwait >= TIMEOUT);
    nacc = tmo ? TIMEOUT : nwait + 1;
    if (wr) last_wdata = wdata;
    erd  = (!wr && !tmo) ? rdata : '0;
    eerr = tmo | slverr;

    @(negedge PCLK);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    PREADY = 1'b0; PSLVERR = 1'b0;
    #1 n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_ready: got %b exp 1", name, req_ready);
    end

    @(negedge PCLK);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
    #1 n_checks++;
    if ({PSEL, PENABLE, req_ready, rsp_valid} !== {esel, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL %s setup_ctl: got sel=%b en=%b rdy=%b rv=%b exp sel=%b 0 0 0",
                         name, PSEL, PENABLE, req_ready, rsp_valid, esel);
    end
    n_checks++;
    if ({PADDR, PWRITE, PWDATA} !== {addr, wr, last_wdata}) begin
      n_fail++; $display("FAIL %s setup_bus: got a=%h w=%b d=%h exp a=%h w=%b d=%h",
                         name, PADDR, PWRITE, PWDATA, addr, wr, last_wdata);
    end

    for (int k = 0; k < nacc; k++) begin
      @(negedge PCLK);
      PREADY  = (k == nwait);
      PSLVERR = (k == nwait) ? slverr : 1'($urandom);
      PRDATA  = (k == nwait) ? rdata : $urandom;
      #1 n_checks++;
      if ({PSEL, PENABLE, req_ready, PADDR} !== {esel, 1'b1, (k == nacc - 1), addr}) begin
        n_fail++; $display("FAIL %s access%0d: got sel=%b en=%b rdy=%b a=%h exp sel=%b 1 %b a=%h",
                           name, k, PSEL, PENABLE, req_ready, PADDR, esel, (k == nacc - 1), addr);
      end
    end

    @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    #1 n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, erd, eerr, tmo}) begin
      n_fail++; $display("FAIL %s rsp: got v=%b d=%h e=%b t=%b exp 1 d=%h e=%b t=%b",
                         name, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, erd, eerr, tmo);
    end
    n_checks++;
    if ({PSEL, PENABLE, req_ready} !== {{NSLV{1'b0}}, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL %s back_idle: got sel=%b en=%b rdy=%b exp 0 0 1",
                         name, PSEL, PENABLE, req_ready);
    end

    @(negedge PCLK);
    #1 n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b0, erd, eerr, tmo}) begin
      n_fail++; $display("FAIL %s rsp_hold: got v=%b d=%h e=%b t=%b exp 0 d=%h e=%b t=%b",
                         name, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, erd, eerr, tmo);
    end
  endtask

  task automatic test_reset;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; last_wdata = '0;
    repeat (2) @(negedge PCLK);
    #1 n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy=%b rv=%b sel=%b en=%b a=%h d=%h exp all 0",
                         req_ready, rsp_valid, PSEL, PENABLE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    #1 n_checks++;
    if ({req_ready, PSEL, PENABLE} !== {1'b1, {NSLV{1'b0}}, 1'b0}) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b sel=%b en=%b exp 1 0 0", req_ready, PSEL, PENABLE);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] rd;
    rd = $urandom;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h400; req_wdata = 32'hCAFE0001;
    @(negedge PCLK);
    req_write = 1'b0; req_addr = 12'h404; req_wdata = 32'h0BADF00D;
    #1 n_checks++;
    if ({PSEL, PENABLE, req_ready} !== {4'b0010, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b2b setup1: got sel=%b en=%b rdy=%b exp 0010 0 0", PSEL, PENABLE, req_ready);
    end
    @(negedge PCLK);
    PREADY = 1'b1; PSLVERR = 1'b0;
    #1 n_checks++;
    if ({PENABLE, req_ready} !== 2'b11) begin
      n_fail++; $display("FAIL b2b access1: got en=%b rdy=%b exp 1 1", PENABLE, req_ready);
    end
    @(negedge PCLK);
    req_valid = 1'b0; PREADY = 1'b0;
    #1 n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA} !==
        {1'b1, 32'h0, 1'b0, 4'b0010, 1'b0, 12'h404, 1'b0, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL b2b setup2: got rv=%b d=%h e=%b sel=%b en=%b a=%h w=%b wd=%h exp 1 0 0 0010 0 404 0 cafe0001",
                         rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA);
    end
    @(negedge PCLK);
    PREADY = 1'b1; PRDATA = rd;
    #1 n_checks++;
    if ({rsp_valid, PENABLE, req_ready} !== 3'b011) begin
      n_fail++; $display("FAIL b2b access2: got rv=%b en=%b rdy=%b exp 0 1 1", rsp_valid, PENABLE, req_ready);
    end
    @(negedge PCLK);
    PREADY = 1'b0;
    #1 n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, PSEL} !== {1'b1, rd, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL b2b rsp2: got rv=%b d=%h e=%b sel=%b exp 1 %h 0 0000", rsp_valid, rsp_rdata, rsp_err, PSEL, rd);
    end
    last_wdata = 32'hCAFE0001;
  endtask

  task automatic test_reset_mid;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'hC20; req_wdata = 32'h55AA55AA;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    PREADY = 1'b0;
    #1 n_checks++;
    if ({PSEL, PENABLE} !== {4'b1000, 1'b1}) begin
      n_fail++; $display("FAIL rstmid in_access: got sel=%b en=%b exp 1000 1", PSEL, PENABLE);
    end
    #1 PRESET = 1'b1;
    #1 n_checks++;
    if ({PSEL, PENABLE, rsp_valid} !== '0) begin
      n_fail++; $display("FAIL rstmid async_drop: got sel=%b en=%b rv=%b exp 0 0 0", PSEL, PENABLE, rsp_valid);
    end
    @(negedge PCLK);
    PRESET = 1'b0; last_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      #1 n_checks++;
      if ({rsp_valid, PSEL} !== '0) begin
        n_fail++; $display("FAIL rstmid no_rsp%0d: got rv=%b sel=%b exp 0 0", k, rsp_valid, PSEL);
      end
    end
    do_xfer(1'b0, 12'h0F0, 32'h0, 1, 1'b0, 32'h89ABCDEF, "rstmid_next");
  endtask

  task automatic test_random;
    int nw;
    for (int i = 0; i < 25; i++) begin
      nw = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      do_xfer(1'($urandom), ADDR_W'($urandom), $urandom, nw, 1'($urandom), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    do_xfer(1'b1, 12'h0A4, 32'hDEADBEEF, 0, 1'b0, 32'h0, "t1_write");
    do_xfer(1'b0, 12'hC10, 32'h0, 3, 1'b0, 32'h12345678, "t2_read_wait");
    test_back_to_back();
    do_xfer(1'b0, 12'h800, 32'h0, 0, 1'b1, 32'hFFFF0000, "t4_slverr");
    do_xfer(1'b0, 12'h3FC, 32'h0, TIMEOUT + 4, 1'b0, 32'h77777777, "t5_timeout");
    do_xfer(1'b1, 12'h500, 32'h13572468, 15, 1'b0, 32'h0, "wait15_no_timeout");
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
